// File: rtl/instr_fetch_stage_if.sv
// Bundle of the instruction-memory request channel and the decode-side
// instruction handshake used by instr_fetch_stage.
interface instr_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        br_taken;
    logic [31:0] br_imm;
    logic        fetch_err;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid, fetch_err,
        input  imem_ack, imem_rdata, instr_ready, br_taken, br_imm
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid, fetch_err,
        output imem_ack, imem_rdata, instr_ready, br_taken, br_imm
    );
endinterface

// File: rtl/instr_fetch_stage.sv
// RV32I fetch stage: one outstanding imem read, latched instruction offered to decode.
// Optional ack-wait timeout enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    instr_fetch_stage_if.master        bus,
    output logic [1:0]                 dbg_state
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        handshake;
    logic        misaligned;

    // Decode handshake: instr is transferred on a rising edge where instr_valid
    // and instr_ready are both high; instr_valid never drops without a transfer
    // except on reset, and instr/instr_pc stay stable while it is high.
    assign handshake  = (state == S_HOLD) && bus.instr_valid && bus.instr_ready;
    assign next_pc    = bus.br_taken ? (bus.instr_pc + bus.br_imm) : (bus.instr_pc + 32'd4);
    assign misaligned = (next_pc[1:0] != 2'b00);

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] wait_cnt;
    logic          timeout;

    assign timeout = (state == S_FETCH) && !bus.imem_ack
                     && (wait_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if ((state == S_FETCH) && !bus.imem_ack && !timeout) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (bus.imem_ack) begin
                    state_next = S_HOLD;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (timeout) begin
                    state_next = S_ERR;
                end
`endif
            end
            S_HOLD: begin
                if (handshake) begin
                    state_next = misaligned ? S_ERR : S_FETCH;
                end
            end
            S_ERR:   state_next = S_ERR;
            default: state_next = S_FETCH;
        endcase
    end

    always_comb begin
        bus.imem_req  = (state == S_FETCH);
        bus.imem_addr = pc;
        bus.fetch_err = (state == S_ERR);
        dbg_state     = state;
    end

    // The faulting target is still loaded into pc so it is visible on imem_addr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc              <= RESET_PC;
            bus.instr       <= 32'd0;
            bus.instr_pc    <= 32'd0;
            bus.instr_valid <= 1'b0;
        end else if ((state == S_FETCH) && bus.imem_ack) begin
            bus.instr       <= bus.imem_rdata;
            bus.instr_pc    <= pc;
            bus.instr_valid <= 1'b1;
        end else if (handshake) begin
            pc              <= next_pc;
            bus.instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_instr_fetch_stage;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int unsigned TIMEOUT_CYC = 16;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         n_checks;
    int         n_fail;

    instr_fetch_stage_if bus ();

    instr_fetch_stage #(
        .RESET_PC    (RESET_PC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pc, the instruction held for decode, sticky error.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_valid;
    logic        m_err;
    int          m_wait;

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_instr = 32'd0;
        m_ipc   = 32'd0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_wait  = 0;
    endtask

    task automatic model_update(input logic a, input logic [31:0] d, input logic r,
                                input logic t, input logic [31:0] imm);
        logic [31:0] nxt;
        if (m_err) begin
            return;
        end
        if (!m_valid) begin
            if (a) begin
                m_valid = 1'b1;
                m_instr = d;
                m_ipc   = m_pc;
                m_wait  = 0;
            end else begin
`ifdef FETCH_TIMEOUT_EN
                m_wait++;
                if (m_wait >= TIMEOUT_CYC) begin
                    m_err  = 1'b1;
                    m_wait = 0;
                end
`endif
            end
        end else if (r) begin
            nxt     = t ? m_ipc + imm : m_ipc + 32'd4;
            m_pc    = nxt;
            m_valid = 1'b0;
            if (nxt[1:0] != 2'b00) m_err = 1'b1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        check("imem_req",    {31'd0, bus.imem_req},    {31'd0, !m_valid && !m_err});
        check("imem_addr",   bus.imem_addr,            m_pc);
        check("instr_valid", {31'd0, bus.instr_valid}, {31'd0, m_valid});
        check("fetch_err",   {31'd0, bus.fetch_err},   {31'd0, m_err});
        if (m_valid) begin
            check("instr",    bus.instr,    m_instr);
            check("instr_pc", bus.instr_pc, m_ipc);
        end
    endtask

    // Called at a negedge: drive inputs, let one rising edge pass, compare.
    task automatic step(input logic a, input logic [31:0] d, input logic r,
                        input logic t, input logic [31:0] imm);
        bus.imem_ack    = a;
        bus.imem_rdata  = d;
        bus.instr_ready = r;
        bus.br_taken    = t;
        bus.br_imm      = imm;
        model_update(a, d, r, t, imm);
        @(negedge clk);
        cmp_model();
    endtask

    // Asynchronous reset asserted mid low-phase; outputs must clear before any edge.
    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1 model_reset();
        cmp_model();
        check("rst_valid_clear", {31'd0, bus.instr_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cmp_model();
    endtask

    initial begin
        logic [31:0] held;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'd0;
        bus.instr_ready = 1'b0;
        bus.br_taken    = 1'b0;
        bus.br_imm      = 32'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cmp_model();
        check("rst_req",   {31'd0, bus.imem_req},    32'd1);
        check("rst_addr",  bus.imem_addr,            32'd0);
        check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("rst_err",   {31'd0, bus.fetch_err},   32'd0);

        // Memory acks every cycle, decode always ready: one accept per 2 cycles.
        step(1'b1, 32'hA000_0001, 1'b1, 1'b0, 32'd0);
        check("t1_valid", {31'd0, bus.instr_valid}, 32'd1);
        check("t1_instr", bus.instr,                32'hA000_0001);
        check("t1_req",   {31'd0, bus.imem_req},    32'd0);
        step(1'b1, 32'hA000_0002, 1'b1, 1'b0, 32'd0);
        check("t1_addr4", bus.imem_addr, 32'd4);
        step(1'b1, 32'hA000_0003, 1'b1, 1'b0, 32'd0);
        check("t1_ipc4",  bus.instr_pc, 32'd4);
        step(1'b1, 32'hA000_0004, 1'b1, 1'b0, 32'd0);
        check("t1_addr8", bus.imem_addr, 32'd8);

        // Backward branch from 0x10 and fall-through from 0x10.
        step(1'b1, 32'hB000_0000, 1'b0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0008);
        check("t2_addr10", bus.imem_addr, 32'h10);
        step(1'b1, 32'hB000_0001, 1'b0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFF8);
        check("t2_taken", bus.imem_addr, 32'h08);
        step(1'b1, 32'hB000_0002, 1'b0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0008);
        step(1'b1, 32'hB000_0003, 1'b0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFF8);
        check("t2_untaken", bus.imem_addr, 32'h14);

        // Decode stalls five cycles while memory keeps acking spuriously.
        held = 32'hC0DE_0014;
        step(1'b1, held, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, $urandom, 1'b0, 1'b0, 32'd0);
            check("t3_instr", bus.instr,             held);
            check("t3_ipc",   bus.instr_pc,          32'h14);
            check("t3_req",   {31'd0, bus.imem_req}, 32'd0);
        end

        // Misaligned branch target 0x26 from 0x20.
        step(1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_000C);
        check("t4_addr20", bus.imem_addr, 32'h20);
        step(1'b1, 32'hD000_0020, 1'b0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0006);
        check("t4_err", {31'd0, bus.fetch_err}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'b1, 1'b0, 32'd0);
            check("t4_err_sticky", {31'd0, bus.fetch_err}, 32'd1);
            check("t4_req_low",    {31'd0, bus.imem_req},  32'd0);
        end
        pulse_reset();

        // PC wrap from 0xFFFF_FFFC to 0 without a fault.
        step(1'b1, 32'hE000_0000, 1'b0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        check("wrap_top", bus.imem_addr, 32'hFFFF_FFFC);
        step(1'b1, 32'hE000_0001, 1'b0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        check("wrap_zero", bus.imem_addr,            32'd0);
        check("wrap_err",  {31'd0, bus.fetch_err},   32'd0);

        // Memory never acks.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
`ifdef FETCH_TIMEOUT_EN
            check("t5_err", {31'd0, bus.fetch_err}, {31'd0, i >= int'(TIMEOUT_CYC) - 1});
`else
            check("t5_req", {31'd0, bus.imem_req},  32'd1);
            check("t5_err", {31'd0, bus.fetch_err}, 32'd0);
`endif
        end
        pulse_reset();

        // Reset while holding a valid instruction; ack right after reset is honoured.
        step(1'b1, 32'hF000_0000, 1'b0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        step(1'b1, 32'hF000_0004, 1'b0, 1'b0, 32'd0);
        check("t6_pre_valid", {31'd0, bus.instr_valid}, 32'd1);
        pulse_reset();
        check("t6_addr", bus.imem_addr, RESET_PC);
        step(1'b1, 32'hF000_1111, 1'b0, 1'b0, 32'd0);
        check("t6_valid", {31'd0, bus.instr_valid}, 32'd1);
        check("t6_ipc",   bus.instr_pc,             RESET_PC);
        check("t6_instr", bus.instr,                32'hF000_1111);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] imm;
            imm = 32'(($urandom_range(0, 255) - 128) * 4);
            if ($urandom_range(0, 19) == 0) imm = imm + 32'($urandom_range(1, 3));
            if ((m_err && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
                     1'($urandom_range(0, 1)), imm);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
